// File: rtl/dwt53_pkg.sv
// Shared definitions for the LeGall 5/3 lifting engines (forward and inverse).
package dwt53_pkg;

   // Row engine sequencing states
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVEN,
      ODD,
      STORE,
      DONE
   } state_t;

   // Default sample/coefficient width (signed two's complement)
   localparam int DWT_WIDTH  = 16;

   // Extra bits carried by intermediate lifting sums so that l + r + 2 cannot overflow
   localparam int GUARD_BITS = 2;

endpackage

// File: rtl/dwt53_lift_inv.sv
// Inverse 5/3 lifting step, purely combinational.
//   even (odd = 0): res = s - floor((l + r + 2) / 4)   undo update
//   odd  (odd = 1): res = s + floor((l + r) / 2)       undo predict
// Sums are carried at WIDTH+GUARD_BITS bits; the result wraps to WIDTH bits.
module dwt53_lift_inv
   import dwt53_pkg::*;
#(
   parameter int WIDTH = DWT_WIDTH
) (
   input  logic signed [WIDTH-1:0] l,
   input  logic signed [WIDTH-1:0] r,
   input  logic signed [WIDTH-1:0] s,
   input  logic                    odd,
   output logic signed [WIDTH-1:0] res
);

   localparam int SW = WIDTH + GUARD_BITS;

   logic signed [SW-1:0] l_ext;
   logic signed [SW-1:0] r_ext;
   logic signed [SW-1:0] s_ext;
   logic signed [SW-1:0] pair_sum;
   logic signed [SW-1:0] adj;

   // Sign-extend operands, form the neighbour sum and apply the selected step
   always_comb begin
      l_ext    = {{GUARD_BITS{l[WIDTH-1]}}, l};
      r_ext    = {{GUARD_BITS{r[WIDTH-1]}}, r};
      s_ext    = {{GUARD_BITS{s[WIDTH-1]}}, s};
      pair_sum = l_ext + r_ext;
      adj      = '0;
      res      = '0;
      if (odd) begin
         adj = pair_sum >>> 1;
         res = WIDTH'(s_ext + adj);
      end else begin
         adj = (pair_sum + SW'(2)) >>> 2;
         res = WIDTH'(s_ext - adj);
      end
   end

endmodule

// File: rtl/dwt53_inv_row.sv
// Inverse LeGall 5/3 row engine: loads one interleaved row (s at even, d at odd
// addresses) from the shared RAM, undoes update then predict in a local buffer,
// and writes the reconstructed samples back in place.
module dwt53_inv_row
   import dwt53_pkg::*;
#(
   parameter int WIDTH   = DWT_WIDTH,
   parameter int ROW_LEN = 64,
   parameter int AW      = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    rd_addr,
   output logic             rd_en,
   input  logic [WIDTH-1:0] rd_data,
   output logic [AW-1:0]    wr_addr,
   output logic             wr_dv,
   output logic [WIDTH-1:0] wr_data
);

   localparam int CW   = $clog2(ROW_LEN + 1);
   localparam int IW   = $clog2(ROW_LEN);
   localparam int HALF = ROW_LEN / 2;

   localparam logic [CW-1:0] CNT_LOAD_END = CW'(ROW_LEN);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ROW_END  = CW'(ROW_LEN - 1);
   localparam logic [IW-2:0] LAST_STEP    = (IW-1)'(HALF - 1);
   localparam logic [IW-1:0] LAST_EVEN    = IW'(ROW_LEN - 2);

   state_t                   state_reg, state_next;
   logic [CW-1:0]            cnt_reg, cnt_next;
   logic [AW-1:0]            base_reg, base_next;

   logic signed [WIDTH-1:0]  row_buf [ROW_LEN];

   logic [IW-2:0]            step;
   logic [IW-1:0]            idx_even, idx_odd, idx_prev_odd, idx_next_even;
   logic                     lift_odd;
   logic signed [WIDTH-1:0]  lift_l, lift_r, lift_s, lift_res;

   logic                     buf_we;
   logic [IW-1:0]            buf_idx;
   logic signed [WIDTH-1:0]  buf_val;

   // Control registers; reset returns the engine to IDLE from any state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         base_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         base_reg  <= base_next;
      end
   end

   // Next-state sequencing: LOAD counts one beyond ROW_LEN to catch the last read return
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      base_next  = base_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               cnt_next   = '0;
               base_next  = base_addr;
            end
         end
         LOAD: begin
            if (cnt_reg == CNT_LOAD_END) begin
               state_next = EVEN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         EVEN: begin
            if (cnt_reg == CNT_HALF_END) begin
               state_next = ODD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ODD: begin
            if (cnt_reg == CNT_HALF_END) begin
               state_next = STORE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         STORE: begin
            if (cnt_reg == CNT_ROW_END) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // RAM port and handshake outputs, decoded from the registered state
   always_comb begin
      busy    = (state_reg == LOAD) || (state_reg == EVEN) ||
                (state_reg == ODD)  || (state_reg == STORE);
      done    = (state_reg == DONE);
      rd_en   = (state_reg == LOAD) && (cnt_reg != CNT_LOAD_END);
      rd_addr = '0;
      wr_dv   = (state_reg == STORE);
      wr_addr = '0;
      wr_data = '0;
      if (rd_en) begin
         rd_addr = base_reg + AW'(cnt_reg);
      end
      if (wr_dv) begin
         wr_addr = base_reg + AW'(cnt_reg);
         wr_data = row_buf[cnt_reg[IW-1:0]];
      end
   end

   // Operand selection for step n, including the mirrored boundaries d[-1]=d[0], x[N]=x[N-2]
   always_comb begin
      step          = cnt_reg[IW-2:0];
      idx_even      = {step, 1'b0};
      idx_odd       = {step, 1'b1};
      idx_prev_odd  = (step == '0) ? IW'(1) : idx_even - IW'(1);
      idx_next_even = (step == LAST_STEP) ? LAST_EVEN : idx_even + IW'(2);
      lift_odd      = (state_reg == ODD);
      if (lift_odd) begin
         lift_l = row_buf[idx_even];
         lift_r = row_buf[idx_next_even];
         lift_s = row_buf[idx_odd];
      end else begin
         lift_l = row_buf[idx_prev_odd];
         lift_r = row_buf[idx_odd];
         lift_s = row_buf[idx_even];
      end
   end

   dwt53_lift_inv #(
      .WIDTH (WIDTH)
   ) u_lift (
      .l   (lift_l),
      .r   (lift_r),
      .s   (lift_s),
      .odd (lift_odd),
      .res (lift_res)
   );

   // Single buffer write port: read returns during LOAD, in-place lifting results otherwise
   always_comb begin
      buf_we  = 1'b0;
      buf_idx = '0;
      buf_val = lift_res;
      case (state_reg)
         LOAD: begin
            buf_we  = (cnt_reg != '0);
            buf_idx = IW'(cnt_reg - CW'(1));
            buf_val = rd_data;
         end
         EVEN: begin
            buf_we  = 1'b1;
            buf_idx = idx_even;
         end
         ODD: begin
            buf_we  = 1'b1;
            buf_idx = idx_odd;
         end
         default: begin
            buf_we = 1'b0;
         end
      endcase
   end

   // Row buffer storage; data only, no reset needed
   always_ff @(posedge clk) begin
      if (buf_we) begin
         row_buf[buf_idx] <= buf_val;
      end
   end

endmodule

// File: tb/tb_dwt53_inv_row.sv
// Directed bench for dwt53_inv_row: a 64-sample and an 8-sample instance, each
// with its own RAM model (one-cycle read latency) and a write/done logger.
module tb_dwt53_inv_row;

   localparam int W  = 16;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;
   logic log_clr;

   logic [1:0]         start, busy, done, rd_en, wr_dv;
   logic [1:0][AW-1:0] base_addr, rd_addr, wr_addr;
   logic [1:0][W-1:0]  rd_data, wr_data;

   logic [1:0]         pl_we;
   logic [AW-1:0]      pl_addr;
   logic [W-1:0]       pl_data;

   logic [W-1:0]       mem       [2][64];
   logic [W-1:0]       wlog_data [2][64];
   logic [AW-1:0]      wlog_addr [2][64];
   int                 wr_cnt[2], done_cnt[2], overlap_cnt[2], start_cyc[2], done_cyc[2];
   int                 cyc = 0;

   logic [W-1:0]       pat [64];
   int                 tests = 0;
   int                 fails = 0;

   always #5 clk = ~clk;

   dwt53_inv_row #(.WIDTH(W), .ROW_LEN(64), .AW(AW)) dut64 (
      .clk       (clk),
      .rst       (rst),
      .start     (start[0]),
      .base_addr (base_addr[0]),
      .busy      (busy[0]),
      .done      (done[0]),
      .rd_addr   (rd_addr[0]),
      .rd_en     (rd_en[0]),
      .rd_data   (rd_data[0]),
      .wr_addr   (wr_addr[0]),
      .wr_dv     (wr_dv[0]),
      .wr_data   (wr_data[0])
   );

   dwt53_inv_row #(.WIDTH(W), .ROW_LEN(8), .AW(AW)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start[1]),
      .base_addr (base_addr[1]),
      .busy      (busy[1]),
      .done      (done[1]),
      .rd_addr   (rd_addr[1]),
      .rd_en     (rd_en[1]),
      .rd_data   (rd_data[1]),
      .wr_addr   (wr_addr[1]),
      .wr_dv     (wr_dv[1]),
      .wr_data   (wr_data[1])
   );

   // RAM models plus write/done/overlap logging for both instances
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rd_en[i]) rd_data[i] <= mem[i][rd_addr[i]];
         if (pl_we[i]) mem[i][pl_addr] <= pl_data;
         else if (wr_dv[i]) mem[i][wr_addr[i]] <= wr_data[i];
         if (start[i] && !busy[i] && !done[i]) start_cyc[i] <= cyc;
         if (log_clr) begin
            wr_cnt[i]      <= 0;
            done_cnt[i]    <= 0;
            overlap_cnt[i] <= 0;
         end else begin
            if (wr_dv[i]) begin
               if (wr_cnt[i] < 64) begin
                  wlog_data[i][wr_cnt[i]] <= wr_data[i];
                  wlog_addr[i][wr_cnt[i]] <= wr_addr[i];
               end
               wr_cnt[i] <= wr_cnt[i] + 1;
            end
            if (done[i]) begin
               done_cnt[i] <= done_cnt[i] + 1;
               done_cyc[i] <= cyc;
            end
            if (rd_en[i] && wr_dv[i]) overlap_cnt[i] <= overlap_cnt[i] + 1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_pat(input int inst, input int base, input int len);
      for (int k = 0; k < len; k++) begin
         pl_we[inst] = 1'b1;
         pl_addr     = AW'((base + k) % 64);
         pl_data     = pat[k];
         @(negedge clk);
      end
      pl_we = '0;
   endtask

   task automatic clear_logs();
      log_clr = 1'b1;
      @(negedge clk);
      log_clr = 1'b0;
   endtask

   task automatic start_row(input int inst, input int base);
      start[inst]     = 1'b1;
      base_addr[inst] = AW'(base);
      @(negedge clk);
      start[inst]     = 1'b0;
   endtask

   task automatic wait_done(input int inst, input int target, input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done_cnt[inst] >= target) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests++; if (busy[i] !== 1'b0)   begin fails++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); end
         tests++; if (done[i] !== 1'b0)   begin fails++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done[i]); end
         tests++; if (rd_en[i] !== 1'b0)  begin fails++; $display("FAIL reset_rd_en[%0d]: got %b expected 0", i, rd_en[i]); end
         tests++; if (wr_dv[i] !== 1'b0)  begin fails++; $display("FAIL reset_wr_dv[%0d]: got %b expected 0", i, wr_dv[i]); end
         tests++; if (rd_addr[i] !== '0)  begin fails++; $display("FAIL reset_rd_addr[%0d]: got %0d expected 0", i, rd_addr[i]); end
         tests++; if (wr_addr[i] !== '0)  begin fails++; $display("FAIL reset_wr_addr[%0d]: got %0d expected 0", i, wr_addr[i]); end
         tests++; if (wr_data[i] !== '0)  begin fails++; $display("FAIL reset_wr_data[%0d]: got %0d expected 0", i, wr_data[i]); end
      end
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset checks done");
   endtask

   // 64-sample rows: constant, round-trip pair, floor behaviour with negatives
   task automatic test_row64();
      int sv_t[3] = '{216, 216, 0};
      int dv_t[3] = '{0, 2, -3};
      int ee_t[3] = '{216, 215, 1};
      int eo_t[3] = '{216, 217, -2};
      bit to;
      logic [W-1:0] exp_v;
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 64; k++) pat[k] = (k % 2 == 0) ? W'(sv_t[v]) : W'(dv_t[v]);
         load_pat(0, 0, 64);
         clear_logs();
         start_row(0, 0);
         wait_done(0, 1, 400, to);
         tests++; if (to) begin fails++; $display("FAIL row64_v%0d_timeout: got no done expected done within 400 cycles", v); end
         tests++; if (wr_cnt[0] !== 64) begin fails++; $display("FAIL row64_v%0d_writes: got %0d expected 64", v, wr_cnt[0]); end
         tests++; if (done_cyc[0] - start_cyc[0] !== 194) begin fails++; $display("FAIL row64_v%0d_latency: got %0d expected 194", v, done_cyc[0] - start_cyc[0]); end
         tests++; if (overlap_cnt[0] !== 0) begin fails++; $display("FAIL row64_v%0d_rd_wr_overlap: got %0d expected 0", v, overlap_cnt[0]); end
         for (int k = 0; k < 64; k++) begin
            exp_v = (k % 2 == 0) ? W'(ee_t[v]) : W'(eo_t[v]);
            tests++;
            if (wlog_data[0][k] !== exp_v || wlog_addr[0][k] !== AW'(k)) begin
               fails++;
               $display("FAIL row64_v%0d_x[%0d]: got data %0d addr %0d expected data %0d addr %0d",
                        v, k, $signed(wlog_data[0][k]), wlog_addr[0][k], $signed(exp_v), k);
            end
         end
         $display("[TB] row64 vector %0d: s=%0d d=%0d writes=%0d latency=%0d", v, sv_t[v], dv_t[v], wr_cnt[0], done_cyc[0] - start_cyc[0]);
      end
   endtask

   // 8-sample rows: left boundary impulse at base 0, right boundary at base 60 (address wrap)
   task automatic test_boundary();
      int exp_t[2][8] = '{'{-2, 2, -1, -1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 4, 8, 8}};
      int base_t[2]   = '{0, 60};
      bit to;
      for (int v = 0; v < 2; v++) begin
         for (int k = 0; k < 8; k++) pat[k] = '0;
         if (v == 0) pat[1] = W'(4);
         else        pat[6] = W'(8);
         load_pat(1, base_t[v], 8);
         clear_logs();
         start_row(1, base_t[v]);
         wait_done(1, 1, 100, to);
         tests++; if (to) begin fails++; $display("FAIL bnd_v%0d_timeout: got no done expected done within 100 cycles", v); end
         tests++; if (wr_cnt[1] !== 8) begin fails++; $display("FAIL bnd_v%0d_writes: got %0d expected 8", v, wr_cnt[1]); end
         tests++; if (done_cyc[1] - start_cyc[1] !== 26) begin fails++; $display("FAIL bnd_v%0d_latency: got %0d expected 26", v, done_cyc[1] - start_cyc[1]); end
         for (int k = 0; k < 8; k++) begin
            tests++;
            if (wlog_data[1][k] !== W'(exp_t[v][k]) || wlog_addr[1][k] !== AW'((base_t[v] + k) % 64)) begin
               fails++;
               $display("FAIL bnd_v%0d_x[%0d]: got data %0d addr %0d expected data %0d addr %0d",
                        v, k, $signed(wlog_data[1][k]), wlog_addr[1][k], exp_t[v][k], (base_t[v] + k) % 64);
            end
         end
         $display("[TB] boundary vector %0d base=%0d writes=%0d", v, base_t[v], wr_cnt[1]);
      end
   endtask

   task automatic test_start_busy();
      bit to;
      for (int k = 0; k < 64; k++) pat[k] = (k % 2 == 0) ? W'(216) : W'(0);
      load_pat(0, 0, 64);
      clear_logs();
      start_row(0, 0);
      repeat (10) @(negedge clk);
      start_row(0, 32);
      wait_done(0, 1, 400, to);
      repeat (250) @(negedge clk);
      tests++; if (to) begin fails++; $display("FAIL busy_start_timeout: got no done expected done within 400 cycles"); end
      tests++; if (done_cnt[0] !== 1) begin fails++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt[0]); end
      tests++; if (wr_cnt[0] !== 64) begin fails++; $display("FAIL busy_start_writes: got %0d expected 64", wr_cnt[0]); end
      tests++; if (done_cyc[0] - start_cyc[0] !== 194) begin fails++; $display("FAIL busy_start_latency: got %0d expected 194", done_cyc[0] - start_cyc[0]); end
      tests++; if (wlog_addr[0][0] !== AW'(0)) begin fails++; $display("FAIL busy_start_first_addr: got %0d expected 0", wlog_addr[0][0]); end
      tests++; if (wlog_addr[0][63] !== AW'(63)) begin fails++; $display("FAIL busy_start_last_addr: got %0d expected 63", wlog_addr[0][63]); end
      tests++; if (wlog_data[0][63] !== W'(216)) begin fails++; $display("FAIL busy_start_last_data: got %0d expected 216", wlog_data[0][63]); end
      $display("[TB] start-while-busy: done pulses=%0d writes=%0d", done_cnt[0], wr_cnt[0]);
   endtask

   // Second start in the cycle after done; second pass runs on the first pass output
   task automatic test_back_to_back();
      int exp_t[16] = '{-2, 2, -1, -1, 0, 0, 0, 0, -3, 0, -1, -2, 0, 0, 0, 0};
      bit to1, to2;
      for (int k = 0; k < 8; k++) pat[k] = '0;
      pat[1] = W'(4);
      load_pat(1, 0, 8);
      clear_logs();
      start_row(1, 0);
      wait_done(1, 1, 100, to1);
      start_row(1, 0);
      wait_done(1, 2, 100, to2);
      tests++; if (to1 || to2) begin fails++; $display("FAIL b2b_timeout: got timeouts %b%b expected 00", to1, to2); end
      tests++; if (done_cnt[1] !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt[1]); end
      tests++; if (wr_cnt[1] !== 16) begin fails++; $display("FAIL b2b_writes: got %0d expected 16", wr_cnt[1]); end
      tests++; if (done_cyc[1] - start_cyc[1] !== 26) begin fails++; $display("FAIL b2b_latency: got %0d expected 26", done_cyc[1] - start_cyc[1]); end
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (wlog_data[1][k] !== W'(exp_t[k]) || wlog_addr[1][k] !== AW'(k % 8)) begin
            fails++;
            $display("FAIL b2b_w[%0d]: got data %0d addr %0d expected data %0d addr %0d",
                     k, $signed(wlog_data[1][k]), wlog_addr[1][k], exp_t[k], k % 8);
         end
      end
      $display("[TB] back-to-back: done pulses=%0d writes=%0d", done_cnt[1], wr_cnt[1]);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 8; k++) pat[k] = '0;
      pat[1] = W'(4);
      load_pat(1, 0, 8);
      clear_logs();
      start_row(1, 0);
      // now one cycle into LOAD; ODD spans cycles 14..17 after acceptance
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if (busy[1] !== 1'b0)  begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy[1]); end
      tests++; if (done[1] !== 1'b0)  begin fails++; $display("FAIL midrst_done: got %b expected 0", done[1]); end
      tests++; if (wr_dv[1] !== 1'b0) begin fails++; $display("FAIL midrst_wr_dv: got %b expected 0", wr_dv[1]); end
      tests++; if (rd_en[1] !== 1'b0) begin fails++; $display("FAIL midrst_rd_en: got %b expected 0", rd_en[1]); end
      repeat (40) @(negedge clk);
      tests++; if (wr_cnt[1] !== 0)   begin fails++; $display("FAIL midrst_writes: got %0d expected 0", wr_cnt[1]); end
      tests++; if (done_cnt[1] !== 0) begin fails++; $display("FAIL midrst_done_count: got %0d expected 0", done_cnt[1]); end
      $display("[TB] mid-operation reset: writes after reset=%0d", wr_cnt[1]);
   endtask

   initial begin
      rst       = 1'b1;
      log_clr   = 1'b1;
      start     = '0;
      base_addr = '0;
      pl_we     = '0;
      pl_addr   = '0;
      pl_data   = '0;
      repeat (3) @(negedge clk);
      log_clr   = 1'b0;
      test_reset();
      test_row64();
      test_boundary();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dwt53_inv_row.md
# dwt53_inv_row

Inverse LeGall 5/3 integer lifting engine for one row of interleaved wavelet coefficients: the reconstruction (decoder) side of the forward lifting datapath. It reads one row of coefficients from the shared dual-port RAM into a local buffer. It then undoes the update step on even samples and the predict step on odd samples, and writes the reconstructed samples back in place. A row or column controller drives it via start/done, so one RAM_2Port instance serves both the forward and the inverse pass.

## Interface
- WIDTH, 16: sample/coefficient width, signed two's complement.
- ROW_LEN, 64: samples per row; even, ≥ 4.
- AW, 6: RAM address width; ROW_LEN ≤ 2^AW.
- clk  in  1: single clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle request; honoured only in IDLE.
- base_addr  in  AW: row start address; sampled with start.
- busy  out  1: high from the cycle after start is accepted until done.
- done  out  1: one-cycle pulse after the last write.
- rd_addr  out  AW, rd_en  out  1: RAM read port; data returns on rd_data one cycle after rd_en.
- rd_data  in  WIDTH: RAM read data.
- wr_addr  out  AW, wr_dv  out  1, wr_data  out  WIDTH: RAM write port.

## Operation
- Memory layout is interleaved. Address base+2n holds low-pass s[n]; address base+2n+1 holds high-pass d[n], for n = 0..ROW_LEN/2-1. All address arithmetic is modulo 2^AW.
- States and transitions:
  - IDLE → LOAD on start.
  - LOAD → EVEN after ROW_LEN reads, once the final data is captured.
  - EVEN → ODD after ROW_LEN/2 steps.
  - ODD → STORE after ROW_LEN/2 steps.
  - STORE → DONE after ROW_LEN writes.
  - DONE → IDLE unconditionally.
- EVEN, step n (ascending): x[2n] = s[n] − floor((d[n−1] + d[n] + 2) / 4). Boundary: d[−1] = d[0].
- ODD, step n (ascending): x[2n+1] = d[n] + floor((x[2n] + x[2n+2]) / 2). Boundary: x[ROW_LEN] = x[ROW_LEN−2]. Uses the EVEN results.
- Both steps are computed in place in the buffer, one step per cycle.
- Arithmetic rules:
  - Sums are formed at WIDTH+2 bits, sign-extended.
  - Divisions are arithmetic right shifts, so floor toward −∞.
  - Results are truncated to WIDTH bits and wrap on overflow; no saturation.
- start while busy is ignored; base_addr is not re-sampled.
- Reset values, also forced on rst at any time including mid-operation:
  - state = IDLE.
  - busy, done, rd_en, wr_dv = 0.
  - rd_addr, wr_addr, wr_data = 0.
- After a mid-operation reset, no further writes are issued. A partial row already written stays in RAM.

## Timing
- Start accepted at edge t. All cycle numbers below are relative to t.
- busy rises at t+1.
- LOAD: rd_en high for cycles t+1..t+ROW_LEN with rd_addr = base+i. Capture takes one extra cycle, so LOAD occupies ROW_LEN+1 cycles.
- EVEN: ROW_LEN/2 cycles. ODD: ROW_LEN/2 cycles.
- STORE: wr_dv high for ROW_LEN consecutive cycles, wr_addr = base+i ascending.
- done high for exactly the cycle after the last write; busy falls in that same cycle.
- Start-to-done latency = 3·ROW_LEN + 2 cycles (194 at ROW_LEN = 64).
- rd_en and wr_dv are never high in the same cycle.
- start may be re-asserted in the cycle after done.

## Structure
- Shared package dwt53_pkg holds:
  - the state enum: IDLE, LOAD, EVEN, ODD, STORE, DONE;
  - the default WIDTH constant;
  - the guard-bit count (2).
- The same package is used by the forward lifting block.
- Sub-module dwt53_lift_inv: purely combinational, with inputs l, r, s and the even/odd select, and output res. It implements both step equations. Structurally it mirrors the forward lifting step.
- The buffer is a register array of ROW_LEN × WIDTH; no extra RAM is needed.

## Test plan
- Constant row: s[n] = 216, d[n] = 0, ROW_LEN = 64 → all 64 written samples = 216; done at cycle 194 after start.
- Round-trip pair: s[n] = 216, d[n] = 2 → x even = 215, x odd = 217 for every n. This matches forward-transform output on 215/217 data.
- Floor check: s[n] = 0, d[n] = −3 → x even = 1, x odd = −2.
- Boundary impulse, ROW_LEN = 8: d[0] = 4, all other coefficients 0 → written row = −2, 2, −1, −1, 0, 0, 0, 0.
- Control:
  - start while busy → ignored; exactly one done pulse.
  - base_addr = 60, ROW_LEN = 8, AW = 6 → addresses wrap 60..63, 0..3.
  - rst asserted during ODD → busy = 0 next cycle, zero writes observed afterwards.
